core_ctrl: RTL
==============

# core_ctrl

Multi-cycle sequencing controller for the core datapath. It fetches an instruction over a ready/request handshake, holds it in an instruction register, and decodes the opcode. It then steps the datapath through execute, optional data-memory access and write-back, driving the immediate-extractor select, ALU operand select, register-file write enable and PC advance. It sits between the instruction/data memory ports and the datapath: register file, ALU and immediate sign-extender.

## Interface
- DATA_WIDTH, 32, instruction/data word width
- TIMEOUT_CYCLES, 16, memory-handshake watchdog limit (used only with CORE_CTRL_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  DATA_WIDTH  fetched instruction
- instruction  out  DATA_WIDTH  instruction register (IR), feeds immediate extractor
- imm_op  out  3  immediate select: IMM_3120 for I-type, 3'b111 otherwise (extractor yields 0)
- alu_src_imm  out  1  ALU operand B = sign-extended immediate
- dmem_req  out  1  data read request
- dmem_ready  in  1  data read complete this cycle
- wb_sel  out  1  write-back source: 0 ALU, 1 memory
- reg_write  out  1  register-file write strobe
- pc_inc  out  1  PC += 4 strobe
- retired  out  1  one-cycle pulse per completed instruction
- trap  out  1  controller halted
- trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req=1 every cycle until imem_ready=1. On that edge, IR<=imem_rdata and go to DECODE.
- DECODE: classify IR[6:0]. Accepted opcodes are OP-IMM 7'b0010011, LOAD 7'b0000011 and OP 7'b0110011. Any accepted opcode goes to EXEC. Any other opcode goes to TRAP with cause 1.
- EXEC: a single cycle. LOAD goes to MEM; the others go to WB.
- MEM: dmem_req=1 until dmem_ready=1, then go to WB.
- WB: reg_write=1, pc_inc=1 and retired=1 for exactly this cycle, then go to FETCH.
- TRAP: sticky. All strobes and requests are 0. Only rst exits it.
- Decode-derived outputs are combinational from IR and hold from DECODE through WB:
  - OP-IMM: imm_op=IMM_3120, alu_src_imm=1, wb_sel=0.
  - LOAD: imm_op=IMM_3120, alu_src_imm=1, wb_sel=1.
  - OP: imm_op=3'b111, alu_src_imm=0, wb_sel=0.
- In FETCH and TRAP: imm_op=3'b111, alu_src_imm=0, wb_sel=0.
- IR loads only in FETCH on imem_ready. It is stable at all other times.

## Timing
- Reset values: state=FETCH, IR=0, trap=0, trap_cause=0. imem_req is 1 as reset deasserts; all other outputs are 0.
- Reset mid-instruction (any state) aborts immediately. No reg_write, pc_inc or retired pulse is produced for the aborted instruction.
- Latency with zero wait states: OP-IMM and OP take 4 cycles from first imem_req to retired; LOAD takes 5.
- Each cycle imem_ready (or dmem_ready) is held low adds one cycle.
- imem_ready is ignored outside FETCH; dmem_ready is ignored outside MEM.
- imem_req and dmem_req are never high in the same cycle.
- Back-to-back: FETCH follows WB directly, so imem_req reasserts the cycle after retired.

## Configuration
- CORE_CTRL_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle in those states while the ready input is low.
  - When the counter reaches TIMEOUT_CYCLES with ready still low, go to TRAP with cause 2.
  - Ready arriving in the same cycle the count hits the limit wins; no trap is taken.
- Not defined: no counter; the controller waits indefinitely and trap_cause never takes value 2.

## Test plan
- Reset then imem_rdata=32'hFFF00093 (addi x1,x0,-1), imem_ready=1 on the first cycle:
  - imm_op=IMM_3120 and alu_src_imm=1 during DECODE–WB.
  - reg_write, pc_inc and retired pulse on cycle 4; wb_sel=0.
- 32'h00402103 (lw), with dmem_ready delayed 2 cycles:
  - dmem_req is high for 3 cycles.
  - wb_sel=1; retired fires on cycle 7.
- 32'h002081B3 (add): imm_op=3'b111, alu_src_imm=0, retired on cycle 4.
- 32'h00000000: trap=1 and trap_cause=1 the cycle after DECODE. No retired pulse. Subsequent imem_ready pulses are ignored until rst.
- With CORE_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - imem_ready held low → trap_cause=2 after 16 FETCH cycles.
  - Repeat with ready rising on cycle 16 → normal DECODE, no trap.
- Assert rst asynchronously mid-MEM of a load: outputs return to reset values immediately, no reg_write pulse, and fetch restarts after deassert.

Source files
------------

// File: rtl/core_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/write-back sequencer for the core datapath.
// Optional memory-handshake watchdog enabled by defining CORE_CTRL_TIMEOUT_EN.
module core_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   input  logic                  imem_ready,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [2:0]            imm_op,
   output logic                  alu_src_imm,
   output logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  wb_sel,
   output logic                  reg_write,
   output logic                  pc_inc,
   output logic                  retired,
   output logic                  trap,
   output logic [1:0]            trap_cause
);

   // state   | meaning
   // FETCH   | request instruction until imem_ready
   // DECODE  | classify opcode, trap on illegal
   // EXEC    | single ALU cycle
   // MEM     | data read until dmem_ready
   // WB      | write back, advance PC, retire
   // TRAP    | halted until reset
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [2:0] IMM_3120  = 3'b000;
   localparam logic [2:0] IMM_NONE  = 3'b111;

   state_t     state;
   logic [6:0] opcode;
   logic       is_load;
   logic       is_imm_type;
   logic       is_legal;
   logic       timeout;

   assign opcode      = instruction[6:0];
   assign is_load     = (opcode == OPC_LOAD);
   assign is_imm_type = (opcode == OPC_OPIMM) || is_load;
   assign is_legal    = is_imm_type || (opcode == OPC_OP);

`ifdef CORE_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_ready;

   assign wait_ready = (state == S_FETCH) ? imem_ready : dmem_ready;
   // A ready arriving on the limit cycle takes priority over the trap.
   assign timeout    = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !wait_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !wait_ready)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FETCH;
         instruction <= '0;
         imem_req    <= 1'b1;
         dmem_req    <= 1'b0;
         reg_write   <= 1'b0;
         pc_inc      <= 1'b0;
         retired     <= 1'b0;
         trap        <= 1'b0;
         trap_cause  <= 2'd0;
      end else begin
         imem_req  <= 1'b0;
         dmem_req  <= 1'b0;
         reg_write <= 1'b0;
         pc_inc    <= 1'b0;
         retired   <= 1'b0;
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  instruction <= imem_rdata;
                  state       <= S_DECODE;
               end else if (timeout) begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= 2'd2;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            S_DECODE: begin
               if (is_legal) begin
                  state <= S_EXEC;
               end else begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= 2'd1;
               end
            end
            S_EXEC: begin
               if (is_load) begin
                  state    <= S_MEM;
                  dmem_req <= 1'b1;
               end else begin
                  state     <= S_WB;
                  reg_write <= 1'b1;
                  pc_inc    <= 1'b1;
                  retired   <= 1'b1;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  state     <= S_WB;
                  reg_write <= 1'b1;
                  pc_inc    <= 1'b1;
                  retired   <= 1'b1;
               end else if (timeout) begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= 2'd2;
               end else begin
                  dmem_req <= 1'b1;
               end
            end
            S_WB: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
            end
            S_TRAP: state <= S_TRAP;
            default: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
            end
         endcase
      end
   end

   // Decode-derived controls follow IR only while an instruction is in flight.
   always_comb begin
      imm_op      = IMM_NONE;
      alu_src_imm = 1'b0;
      wb_sel      = 1'b0;
      if ((state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB)
          && is_imm_type) begin
         imm_op      = IMM_3120;
         alu_src_imm = 1'b1;
         wb_sel      = is_load;
      end
   end

endmodule
